// File: rtl/mp3_pkg.sv
// Shared types and constants for the MP3 granule sample path.
// Used by the granule sample buffer and its storage banks.
package mp3_pkg;

    localparam int GRANULE_SAMPLES = 576;
    localparam int MAX_BIG_VALUES  = 288;
    localparam int PAIR_W          = 9;

    typedef logic signed [15:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        ZERO,
        DRAIN
    } gsb_state_t;

    function automatic logic [PAIR_W-1:0] clamp_bv(input logic [PAIR_W-1:0] bv);
        return (bv > PAIR_W'(MAX_BIG_VALUES)) ? PAIR_W'(MAX_BIG_VALUES) : bv;
    endfunction

endpackage

// File: rtl/sample_bank_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Read data holds its value while read enable is low.
module sample_bank_ram #(
    parameter int DEPTH = 288,
    parameter int W     = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/granule_sample_buffer.sv
// Collects decoded (x,y) pairs of one granule, zero-fills the rest,
// then streams all lines in order over valid/ready.
module granule_sample_buffer #(
    parameter int GRANULE_SAMPLES = 576,
    parameter int SAMPLE_W        = 16,
    parameter int IDX_W           = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [8:0]                 big_values,
    input  logic                       in_valid,
    input  logic signed [SAMPLE_W-1:0] x_val,
    input  logic signed [SAMPLE_W-1:0] y_val,
    output logic                       busy,
    output logic                       overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [SAMPLE_W-1:0] out_sample,
    output logic [IDX_W-1:0]           out_index,
    output logic                       out_last,
    output logic                       done
);

    import mp3_pkg::*;

    localparam int PAIRS = GRANULE_SAMPLES / 2;

    gsb_state_t          state_q, state_d;
    logic [PAIR_W-1:0]   bv_q, bv_d;
    logic [PAIR_W-1:0]   pair_q, pair_d;
    logic [IDX_W-1:0]    rd_q, rd_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                ov_q, ov_d;
    logic                vld_q, vld_d;
    logic                done_q, done_d;

    logic                we, re, fire, last_fire;
    logic [SAMPLE_W-1:0] wx, wy;
    logic [SAMPLE_W-1:0] rd_even, rd_odd;
    logic [PAIR_W-1:0]   bv_in;

    assign bv_in     = clamp_bv(big_values);
    assign fire      = vld_q & out_ready;
    assign last_fire = fire && (idx_q == IDX_W'(GRANULE_SAMPLES - 1));

    always_comb begin
        state_d = state_q;
        bv_d    = bv_q;
        pair_d  = pair_q;
        rd_d    = rd_q;
        idx_d   = idx_q;
        ov_d    = ov_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        wx      = '0;
        wy      = '0;
        // Pairs arriving while busy but not filling are dropped and flagged.
        if (in_valid && state_q != IDLE && state_q != FILL) begin
            ov_d = 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bv_d    = bv_in;
                    ov_d    = 1'b0;
                    pair_d  = '0;
                    rd_d    = '0;
                    state_d = (bv_in != '0) ? FILL : ZERO;
                end
            end
            FILL: begin
                if (in_valid) begin
                    we     = 1'b1;
                    wx     = x_val;
                    wy     = y_val;
                    pair_d = pair_q + 1'b1;
                    if (pair_q + 1'b1 == bv_q) begin
                        state_d = (bv_q < PAIR_W'(MAX_BIG_VALUES)) ? ZERO : DRAIN;
                    end
                end
            end
            ZERO: begin
                we     = 1'b1;
                pair_d = pair_q + 1'b1;
                if (pair_q == PAIR_W'(PAIRS - 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Prefetch the next line whenever the output slot frees up.
                re = (rd_q < IDX_W'(GRANULE_SAMPLES)) && (!vld_q || out_ready);
                if (re) begin
                    rd_d  = rd_q + 1'b1;
                    idx_d = rd_q;
                    vld_d = 1'b1;
                end else if (fire) begin
                    vld_d = 1'b0;
                end
                if (last_fire) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bv_q    <= '0;
            pair_q  <= '0;
            rd_q    <= '0;
            idx_q   <= '0;
            ov_q    <= 1'b0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bv_q    <= bv_d;
            pair_q  <= pair_d;
            rd_q    <= rd_d;
            idx_q   <= idx_d;
            ov_q    <= ov_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    sample_bank_ram #(.DEPTH(PAIRS), .W(SAMPLE_W), .AW(PAIR_W)) u_even (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (pair_q),
        .wdata_i (wx),
        .re_i    (re),
        .raddr_i (rd_q[IDX_W-1:1]),
        .rdata_o (rd_even)
    );

    sample_bank_ram #(.DEPTH(PAIRS), .W(SAMPLE_W), .AW(PAIR_W)) u_odd (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (pair_q),
        .wdata_i (wy),
        .re_i    (re),
        .raddr_i (rd_q[IDX_W-1:1]),
        .rdata_o (rd_odd)
    );

    assign busy       = (state_q != IDLE);
    assign overflow   = ov_q;
    assign out_valid  = vld_q;
    assign out_index  = idx_q;
    assign out_last   = vld_q && (idx_q == IDX_W'(GRANULE_SAMPLES - 1));
    assign out_sample = vld_q ? (idx_q[0] ? rd_odd : rd_even) : '0;
    assign done       = done_q;

endmodule

// File: tb/tb_granule_sample_buffer.sv
// Randomised bench for granule_sample_buffer with a line-array model
// and a per-cycle output checker.
module tb_granule_sample_buffer;

    localparam int N = 576;
    localparam int P = 288;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [8:0]         big_values = '0;
    logic               in_valid = 1'b0;
    logic signed [15:0] x_val = '0;
    logic signed [15:0] y_val = '0;
    logic               out_ready = 1'b1;
    logic               busy, overflow, out_valid, out_last, done;
    logic signed [15:0] out_sample;
    logic [9:0]         out_index;

    always #5 clk = ~clk;

    granule_sample_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .big_values (big_values),
        .in_valid   (in_valid),
        .x_val      (x_val),
        .y_val      (y_val),
        .busy       (busy),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_index  (out_index),
        .out_last   (out_last),
        .done       (done)
    );

    int compared = 0;
    int mismatched = 0;
    int model_mem [N];
    int captured [N];
    int px [P];
    int py [P];
    int exp_idx = 0;
    bit done_exp = 1'b0;
    bit held = 1'b0;
    int h_idx, h_smp;
    int gdone = 0;
    bit rand_ready = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rs16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    // Expected granule: line 2k/2k+1 from pair k if k < clamped count, else 0.
    task automatic set_model(input int bv_raw);
        int bvc;
        bvc = (bv_raw > P) ? P : bv_raw;
        for (int n = 0; n < N; n++) begin
            if (n / 2 < bvc) model_mem[n] = (n % 2 == 1) ? py[n/2] : px[n/2];
            else model_mem[n] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            exp_idx = 0;
            done_exp = 1'b0;
            held = 1'b0;
        end else begin
            if (done_exp || done) begin
                check("done_pulse", int'(done), int'(done_exp));
                if (done_exp) check("valid_in_done_cycle", int'(out_valid), 0);
            end
            done_exp = 1'b0;
            if (held) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_index", int'(out_index), h_idx);
                check("stall_sample", int'(out_sample), h_smp);
            end
            held = 1'b0;
            if (out_valid) begin
                check("index", int'(out_index), exp_idx);
                check("sample", int'(out_sample), model_mem[exp_idx]);
                check("last", int'(out_last), int'(exp_idx == N - 1));
                if (out_ready) begin
                    captured[exp_idx] = int'(out_sample);
                    if (exp_idx == N - 1) begin
                        exp_idx = 0;
                        done_exp = 1'b1;
                        gdone++;
                    end else begin
                        exp_idx++;
                    end
                end else begin
                    held = 1'b1;
                    h_idx = int'(out_index);
                    h_smp = int'(out_sample);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic do_start(input int bv);
        big_values = 9'(bv);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_pair(input int x, input int y);
        x_val = 16'(x);
        y_val = 16'(y);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_overflow"}, int'(overflow), 0);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_out_sample"}, int'(out_sample), 0);
        check({tag, "_out_index"}, int'(out_index), 0);
        check({tag, "_out_last"}, int'(out_last), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    // Full-rate drain: first valid within [lo,hi] cycles, then 576 cycles to done.
    task automatic measure(input string tag, input int lo, input int hi);
        int n, m;
        n = 0;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
        end
        check({tag, "_first_valid_in_range"}, int'(n >= lo && n <= hi), 1);
        m = 0;
        while (!done && m < 2000) begin
            tick();
            m++;
        end
        check({tag, "_cycles_to_done"}, m, N);
        tick();
    endtask

    task automatic wait_granule(input string tag);
        int g0, n;
        g0 = gdone;
        n = 0;
        while (gdone == g0 && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_granule_done"}, gdone - g0, 1);
        tick();
        tick();
    endtask

    initial begin
        int bv, bvc, n;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outs("reset");
        rst = 1'b0;
        tick();

        // Three literal pairs, full-rate drain.
        px[0] = 1;    py[0] = -1;
        px[1] = 15;   py[1] = 0;
        px[2] = -200; py[2] = 7;
        set_model(3);
        do_start(3);
        check("t1_busy", int'(busy), 1);
        for (int k = 0; k < 3; k++) begin
            send_pair(px[k], py[k]);
            if (k < 2) repeat ($urandom_range(0, 2)) tick();
        end
        measure("t1", 286, 287);
        check("t1_line0", captured[0], 1);
        check("t1_line1", captured[1], -1);
        check("t1_line4", captured[4], -200);
        check("t1_line5", captured[5], 7);
        check("t1_line6", captured[6], 0);
        check("t1_line575", captured[575], 0);
        check("t1_overflow", int'(overflow), 0);
        check("t1_idle", int'(busy), 0);

        // No pairs: FILL skipped, 288 zero-fill cycles.
        set_model(0);
        do_start(0);
        measure("t2", 289, 290);
        check("t2_overflow", int'(overflow), 0);

        // Oversized count clamps to 288; zero-fill never entered.
        for (int k = 0; k < P; k++) begin
            px[k] = k;
            py[k] = -k;
        end
        set_model(300);
        do_start(300);
        for (int k = 0; k < P; k++) send_pair(px[k], py[k]);
        measure("t3", 1, 2);
        check("t3_line200", captured[200], 100);
        check("t3_line201", captured[201], -100);
        check("t3_line575", captured[575], -287);

        // Random counts and data with random backpressure.
        rand_ready = 1'b1;
        repeat (3) begin
            bv = $urandom_range(0, 511);
            bvc = (bv > P) ? P : bv;
            for (int k = 0; k < P; k++) begin
                px[k] = rs16();
                py[k] = rs16();
            end
            set_model(bv);
            do_start(bv);
            for (int k = 0; k < bvc; k++) begin
                send_pair(px[k], py[k]);
                repeat ($urandom_range(0, 1)) tick();
            end
            wait_granule("t4");
        end

        // Stray pair in zero-fill and a start mid-drain.
        px[0] = 123; py[0] = -456;
        px[1] = -7;  py[1] = 32767;
        set_model(2);
        do_start(2);
        send_pair(px[0], py[0]);
        send_pair(px[1], py[1]);
        send_pair(999, -999);
        check("t5_overflow_set", int'(overflow), 1);
        n = 0;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
        end
        repeat (20) tick();
        do_start(5);
        check("t5_busy_after_ignored_start", int'(busy), 1);
        check("t5_overflow_kept", int'(overflow), 1);
        wait_granule("t5");
        check("t5_overflow_sticky", int'(overflow), 1);
        set_model(0);
        do_start(0);
        check("t5_overflow_cleared", int'(overflow), 0);
        wait_granule("t5b");

        // Async reset mid-fill, then a fresh short granule.
        do_start(20);
        for (int k = 0; k < 10; k++) send_pair(1000 + k, -1000 - k);
        #2 rst = 1'b1;
        #1;
        check_idle_outs("midrst");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        px[0] = -32768; py[0] = 5;
        px[1] = 42;     py[1] = -42;
        px[2] = 777;    py[2] = 777;
        set_model(2);
        do_start(2);
        send_pair(px[0], py[0]);
        send_pair(px[1], py[1]);
        wait_granule("t6");
        check("t6_line0", captured[0], -32768);
        check("t6_line3", captured[3], -42);
        check("t6_line4_not_stale", captured[4], 0);
        check("t6_line19_not_stale", captured[19], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
